// File: rtl/memory_scan_ctrl.sv
// Pattern-memory scan controller: reads every word, compares it with a latched key and keeps a
// two-digit BCD result. Define MEMSCAN_FIRST_HIT_EN to stop at the first match and report its address.
module memory_scan_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              iClk,
    input  logic              irst,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iSwitch,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRdEn,
    input  logic [DATA_W-1:0] iRdData,
    output logic [3:0]        oUnidades,
    output logic [3:0]        oDecenas,
    output logic              oBusy,
    output logic              oDone,
    output logic              oFound
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCmp, StDone} stateT;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LastWait = 3'(READ_LAT - 1);

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] keyQ, keyD;
    logic [2:0]        waitQ, waitD;
    logic [3:0]        uniQ, uniD;
    logic [3:0]        decQ, decD;
    logic              foundQ, foundD;
    logic              rdEnQ, rdEnD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;
    logic              match;

    assign match = (iRdData == keyQ);

`ifdef MEMSCAN_FIRST_HIT_EN
    logic [3:0] addrUni, addrDec;

    // Addresses of 100 and above cannot be shown in two digits, so they pin at 99.
    always_comb begin
        addrUni = 4'd9;
        addrDec = 4'd9;
        if (int'(addrQ) < 100) begin
            addrDec = 4'(int'(addrQ) / 10);
            addrUni = 4'(int'(addrQ) % 10);
        end
    end
`endif

    always_ff @(posedge iClk) begin
        if (!irst) begin
            stateQ <= StIdle;
            addrQ  <= '0;
            keyQ   <= '0;
            waitQ  <= '0;
            uniQ   <= '0;
            decQ   <= '0;
            foundQ <= 1'b0;
            rdEnQ  <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            addrQ  <= addrD;
            keyQ   <= keyD;
            waitQ  <= waitD;
            uniQ   <= uniD;
            decQ   <= decD;
            foundQ <= foundD;
            rdEnQ  <= rdEnD;
            busyQ  <= busyD;
            doneQ  <= doneD;
        end
    end

    always_comb begin
        stateD = stateQ;
        addrD  = addrQ;
        keyD   = keyQ;
        waitD  = waitQ;
        uniD   = uniQ;
        decD   = decQ;
        foundD = foundQ;

        unique case (stateQ)
            StIdle, StDone: begin
                if (iStart) begin
                    keyD   = iSwitch;
                    uniD   = 4'd0;
                    decD   = 4'd0;
                    addrD  = '0;
                    foundD = 1'b0;
                    stateD = StIssue;
                end
            end
            StIssue: begin
                waitD  = 3'd0;
                stateD = StWait;
            end
            StWait: begin
                if (waitQ == LastWait) begin
                    stateD = StCmp;
                end else begin
                    waitD = waitQ + 3'd1;
                end
            end
            StCmp: begin
`ifdef MEMSCAN_FIRST_HIT_EN
                if (match) begin
                    uniD   = addrUni;
                    decD   = addrDec;
                    foundD = 1'b1;
                    stateD = StDone;
                end else if (addrQ == LastAddr) begin
                    foundD = 1'b0;
                    stateD = StDone;
                end else begin
                    addrD  = addrQ + 1'b1;
                    stateD = StIssue;
                end
`else
                // Saturating BCD increment: 99 absorbs any further matches.
                if (match && !(decQ == 4'd9 && uniQ == 4'd9)) begin
                    if (uniQ == 4'd9) begin
                        uniD = 4'd0;
                        decD = decQ + 4'd1;
                    end else begin
                        uniD = uniQ + 4'd1;
                    end
                end
                if (addrQ == LastAddr) begin
                    foundD = (uniD != 4'd0) || (decD != 4'd0);
                    stateD = StDone;
                end else begin
                    addrD  = addrQ + 1'b1;
                    stateD = StIssue;
                end
`endif
            end
            default: stateD = StIdle;
        endcase

        rdEnD = (stateD == StIssue);
        busyD = (stateD == StIssue) || (stateD == StWait) || (stateD == StCmp);
        doneD = (stateD == StDone);
    end

    assign oAddr     = addrQ;
    assign oRdEn     = rdEnQ;
    assign oUnidades = uniQ;
    assign oDecenas  = decQ;
    assign oBusy     = busyQ;
    assign oDone     = doneQ;
    assign oFound    = foundQ;

endmodule

// File: tb/tb_memory_scan_ctrl.sv
// Bench for memory_scan_ctrl: three instances (default, READ_LAT=3, DEPTH=128) checked each cycle
// against a scan-timeline model, plus literal result checks. Honours MEMSCAN_FIRST_HIT_EN.
module tb_memory_scan_ctrl;

    logic            iClk;
    logic            rstN;
    logic [2:0]      start;
    logic [2:0][7:0] sw;
    logic [2:0][7:0] rdData;
    logic [3:0]      addr0, addr1;
    logic [6:0]      addr2;
    logic [2:0]      rdEn, busy, done, found;
    logic [2:0][3:0] uni, dec;

    logic [7:0] mem [3][128];
    logic       pv  [3][8];
    int         pa  [3][8];

    int         ph      [3] = '{default: 0};  // 0 idle, 1 scanning, 2 done
    int         tm      [3] = '{default: 0};  // cycles since the accepted start edge
    int         finSc   [3] = '{default: 0};
    int         finAddr [3] = '{default: 0};
    logic       finFd   [3] = '{default: 1'b0};
    logic [7:0] keyM    [3] = '{default: 8'h00};
    logic       modelOk = 1'b0;

    int nPass   = 0;
    int nChecks = 0;

    memory_scan_ctrl u0 (
        .iClk(iClk), .irst(rstN), .iStart(start[0]), .iSwitch(sw[0]), .oAddr(addr0),
        .oRdEn(rdEn[0]), .iRdData(rdData[0]), .oUnidades(uni[0]), .oDecenas(dec[0]),
        .oBusy(busy[0]), .oDone(done[0]), .oFound(found[0])
    );
    memory_scan_ctrl #(.READ_LAT(3)) u1 (
        .iClk(iClk), .irst(rstN), .iStart(start[1]), .iSwitch(sw[1]), .oAddr(addr1),
        .oRdEn(rdEn[1]), .iRdData(rdData[1]), .oUnidades(uni[1]), .oDecenas(dec[1]),
        .oBusy(busy[1]), .oDone(done[1]), .oFound(found[1])
    );
    memory_scan_ctrl #(.ADDR_W(7), .DEPTH(128)) u2 (
        .iClk(iClk), .irst(rstN), .iStart(start[2]), .iSwitch(sw[2]), .oAddr(addr2),
        .oRdEn(rdEn[2]), .iRdData(rdData[2]), .oUnidades(uni[2]), .oDecenas(dec[2]),
        .oBusy(busy[2]), .oDone(done[2]), .oFound(found[2])
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    function automatic int depthOf(int i); return (i == 2) ? 128 : 16; endfunction
    function automatic int latOf(int i); return (i == 1) ? 3 : 1; endfunction
    function automatic int perOf(int i); return 2 + latOf(i); endfunction
    function automatic int sat99(int v); return (v > 99) ? 99 : v; endfunction

    function automatic int addrOf(int i);
        case (i)
            0:       return int'(addr0);
            1:       return int'(addr1);
            default: return int'(addr2);
        endcase
    endfunction

    function automatic int countMatch(int i, logic [7:0] k, int n);
        int c = 0;
        for (int j = 0; j < n; j++) if (mem[i][j] == k) c++;
        return c;
    endfunction

    function automatic int firstHit(int i, logic [7:0] k);
        for (int j = 0; j < depthOf(i); j++) if (mem[i][j] == k) return j;
        return -1;
    endfunction

    function automatic int scanLen(int i, logic [7:0] k);
`ifdef MEMSCAN_FIRST_HIT_EN
        int h = firstHit(i, k);
        if (h >= 0) return (h + 1) * perOf(i);
`endif
        return depthOf(i) * perOf(i);
    endfunction

    function automatic logic [18:0] actOf(int i);
        return {7'(addrOf(i)), rdEn[i], busy[i], done[i], found[i], dec[i], uni[i]};
    endfunction

    // Memory: data appears READ_LAT cycles after the strobe cycle and holds until the next read.
    always @(posedge iClk) begin
        for (int i = 0; i < 3; i++) begin
            if (latOf(i) == 1) begin
                if (rdEn[i] == 1'b1) rdData[i] <= mem[i][addrOf(i)];
            end else if (pv[i][latOf(i) - 2] == 1'b1) begin
                rdData[i] <= mem[i][pa[i][latOf(i) - 2]];
            end
            pv[i][0] <= rdEn[i];
            pa[i][0] <= addrOf(i);
            for (int k = 1; k < 8; k++) begin
                pv[i][k] <= pv[i][k - 1];
                pa[i][k] <= pa[i][k - 1];
            end
        end
    end

    // Scan timeline model: phase, elapsed cycles and final result per instance.
    always @(posedge iClk) begin
        modelOk <= modelOk | !rstN;
        for (int i = 0; i < 3; i++) begin
            if (!rstN) begin
                ph[i]   <= 0;
                tm[i]   <= 0;
                keyM[i] <= 8'h00;
            end else if (ph[i] != 1) begin
                if (start[i]) begin
                    ph[i]   <= 1;
                    tm[i]   <= 0;
                    keyM[i] <= sw[i];
                end
            end else if (tm[i] + 1 == scanLen(i, keyM[i])) begin
                ph[i] <= 2;
`ifdef MEMSCAN_FIRST_HIT_EN
                if (firstHit(i, keyM[i]) >= 0) begin
                    finSc[i]   <= sat99(firstHit(i, keyM[i]));
                    finFd[i]   <= 1'b1;
                    finAddr[i] <= firstHit(i, keyM[i]);
                end else begin
                    finSc[i]   <= 0;
                    finFd[i]   <= 1'b0;
                    finAddr[i] <= depthOf(i) - 1;
                end
`else
                finSc[i]   <= sat99(countMatch(i, keyM[i], depthOf(i)));
                finFd[i]   <= (countMatch(i, keyM[i], depthOf(i)) > 0);
                finAddr[i] <= depthOf(i) - 1;
`endif
            end else begin
                tm[i] <= tm[i] + 1;
            end
        end
    end

    task automatic compareAll();
        int eAddr, eSc;
        logic eRd, eBusy, eDone, eFd;
        logic [18:0] expV, actV;
        if (!modelOk) return;
        for (int i = 0; i < 3; i++) begin
            eAddr = 0; eSc = 0; eRd = 1'b0; eBusy = 1'b0; eDone = 1'b0; eFd = 1'b0;
            if (ph[i] == 1) begin
                eAddr = tm[i] / perOf(i);
                eRd   = (tm[i] % perOf(i) == 0);
                eBusy = 1'b1;
`ifndef MEMSCAN_FIRST_HIT_EN
                eSc   = sat99(countMatch(i, keyM[i], eAddr));
`endif
            end else if (ph[i] == 2) begin
                eAddr = finAddr[i];
                eSc   = finSc[i];
                eDone = 1'b1;
                eFd   = finFd[i];
            end
            expV = {7'(eAddr), eRd, eBusy, eDone, eFd, 4'(eSc / 10), 4'(eSc % 10)};
            actV = actOf(i);
            nChecks++;
            if (actV === expV) nPass++;
            else $display("FAIL cycle dut%0d t=%0t: got addr=%0d rdEn=%b busy=%b done=%b found=%b bcd=%h, want addr=%0d rdEn=%b busy=%b done=%b found=%b bcd=%h",
                          i, $time, actV[18:12], actV[11], actV[10], actV[9], actV[8], actV[7:0],
                          expV[18:12], expV[11], expV[10], expV[9], expV[8], expV[7:0]);
        end
    endtask

    task automatic tick();
        @(negedge iClk);
        compareAll();
    endtask

    task automatic expectEq(string name, int got, int want);
        nChecks++;
        if (got == want) nPass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Starts a scan on instance i and returns the edge (counted from the start edge) of oDone.
    task automatic runScan(int i, logic [7:0] k, int toggleAt, logic [7:0] swMid, bit spam,
                           output int doneEdge);
        doneEdge = -1;
        sw[i]    = k;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        for (int c = 0; c <= depthOf(i) * perOf(i) + 20; c++) begin
            if (done[i] == 1'b1) begin
                doneEdge = c;
                break;
            end
            if (c == toggleAt) sw[i] = swMid;
            if (spam) start[i] = (c < 30) && ($urandom_range(1) == 1);
            tick();
        end
        start[i] = 1'b0;
        if (doneEdge < 0) begin
            nChecks++;
            $display("FAIL timeout dut%0d: got no oDone, want oDone within %0d cycles",
                     i, depthOf(i) * perOf(i));
        end
    endtask

    task automatic fillMem(int i, int maxVal);
        for (int j = 0; j < 128; j++) mem[i][j] = 8'($urandom_range(maxVal));
    endtask

    initial begin
        int de;
        logic [7:0] k;
        rstN  = 1'b0;
        start = '0;
        sw    = '0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 128; j++) mem[i][j] = 8'h00;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) expectEq($sformatf("reset outputs dut%0d", i), int'(actOf(i)), 0);
        rstN = 1'b1;
        tick();

        // All-zero memory, key 0.
        runScan(0, 8'h00, -1, 8'h00, 1'b0, de);
`ifdef MEMSCAN_FIRST_HIT_EN
        expectEq("zero mem done edge", de, 3);
        expectEq("zero mem bcd", int'({dec[0], uni[0]}), 'h00);
`else
        expectEq("zero mem done edge", de, 48);
        expectEq("zero mem bcd", int'({dec[0], uni[0]}), 'h16);
`endif
        expectEq("zero mem found", int'(found[0]), 1);
        tick();

        // 0x55 at 2, 7, 15; key switched away mid-scan must not matter.
        fillMem(0, 'h54);
        mem[0][2] = 8'h55; mem[0][7] = 8'h55; mem[0][15] = 8'h55;
        runScan(0, 8'h55, 4, 8'h00, 1'b0, de);
`ifdef MEMSCAN_FIRST_HIT_EN
        expectEq("key latch bcd", int'({dec[0], uni[0]}), 'h02);
`else
        expectEq("key latch bcd", int'({dec[0], uni[0]}), 'h03);
`endif
        expectEq("key latch found", int'(found[0]), 1);

        // READ_LAT=3 instance with five planted matches.
        fillMem(1, 'h9F);
        mem[1][1] = 8'hA5; mem[1][4] = 8'hA5; mem[1][8] = 8'hA5;
        mem[1][12] = 8'hA5; mem[1][13] = 8'hA5;
        runScan(1, 8'hA5, -1, 8'h00, 1'b0, de);
`ifdef MEMSCAN_FIRST_HIT_EN
        expectEq("lat3 done edge", de, 10);
        expectEq("lat3 bcd", int'({dec[1], uni[1]}), 'h01);
`else
        expectEq("lat3 done edge", de, 80);
        expectEq("lat3 bcd", int'({dec[1], uni[1]}), 'h05);
`endif

        // DEPTH=128, every word matches: walks through the carries and saturates.
        for (int j = 0; j < 128; j++) mem[2][j] = 8'h3C;
        runScan(2, 8'h3C, -1, 8'h00, 1'b0, de);
`ifdef MEMSCAN_FIRST_HIT_EN
        expectEq("big bcd", int'({dec[2], uni[2]}), 'h00);
`else
        expectEq("big done edge", de, 384);
        expectEq("big bcd", int'({dec[2], uni[2]}), 'h99);
`endif
        expectEq("big found", int'(found[2]), 1);

        // Matches at 11 and 14; reset lands mid-scan, then a clean rerun with start spam.
        fillMem(0, 'h6A);
        mem[0][11] = 8'h6B; mem[0][14] = 8'h6B;
        sw[0] = 8'h6B;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rstN = 1'b0;
        tick();
        expectEq("mid-scan reset outputs", int'(actOf(0)), 0);
        rstN = 1'b1;
        tick();
        runScan(0, 8'h6B, -1, 8'h00, 1'b1, de);
`ifdef MEMSCAN_FIRST_HIT_EN
        expectEq("rerun done edge", de, 36);
        expectEq("rerun bcd", int'({dec[0], uni[0]}), 'h11);
`else
        expectEq("rerun done edge", de, 48);
        expectEq("rerun bcd", int'({dec[0], uni[0]}), 'h02);
`endif
        expectEq("rerun found", int'(found[0]), 1);

        // Key absent from memory.
        fillMem(0, 'hFE);
        runScan(0, 8'hFF, -1, 8'h00, 1'b0, de);
        expectEq("absent done edge", de, 48);
        expectEq("absent bcd", int'({dec[0], uni[0]}), 'h00);
        expectEq("absent found", int'(found[0]), 0);

        // Start held high re-triggers each time DONE is reached.
        start[0] = 1'b1;
        repeat (150) tick();
        start[0] = 1'b0;
        repeat (60) tick();
        expectEq("held start settles done", int'(done[0]), 1);

        // Randomised scans across all instances.
        for (int n = 0; n < 24; n++) begin
            int i, dens;
            i    = (n % 8 == 7) ? 2 : int'($urandom_range(1));
            k    = 8'($urandom_range(255));
            dens = int'($urandom_range(4));
            for (int j = 0; j < 128; j++)
                mem[i][j] = ($urandom_range(3) < dens) ? k : 8'($urandom_range(255));
            runScan(i, k, int'($urandom_range(40)), 8'($urandom_range(255)),
                    1'($urandom_range(1)), de);
            repeat (int'($urandom_range(3))) tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
